// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and branch handling,
// multi-cycle data-memory wait with timeout, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic [1:0]       resultSrcE,
  input  logic             pcSrcE,
  input  logic             memReqM,
  input  logic             memAckM,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             stallE,
  output logic             flushE,
  output logic             stallM,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             memErr_q, memErr_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic lwStall, memStall, timingOut;

  // MEM result beats WB result when both target the same source register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign forwardAE = fwd_sel(rs1E, rdM, regWriteM, rdW, regWriteW);
  assign forwardBE = fwd_sel(rs2E, rdM, regWriteM, rdW, regWriteW);

  assign lwStall   = (resultSrcE == 2'b01) && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign timingOut = (state_q == MEM_WAIT) && (tcnt_q == TO_LAST) && !memAckM;
  assign memStall  = ((state_q == RUN) && memReqM && !memAckM) ||
                     ((state_q == MEM_WAIT) && !memAckM && !timingOut);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      tcnt_q     <= 8'd0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    memErr_d = memErr_q;
    case (state_q)
      RUN: begin
        if (memReqM && !memAckM) begin
          state_d = MEM_WAIT;
          tcnt_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (memAckM) begin
          state_d = RUN;
        end else if (timingOut) begin
          state_d  = RUN;
          memErr_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stall/flush outputs are held low for as long as reset is asserted.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    stallE = 1'b0;
    flushE = 1'b0;
    stallM = 1'b0;
    flushW = 1'b0;
    if (!rst) begin
      if (memStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lwStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  assign stallCnt_d = (stallF && (stallCnt_q != {CNT_W{1'b1}})) ? stallCnt_q + CNT_W'(1)
                                                                : stallCnt_q;

  assign memErr   = memErr_q;
  assign stallCnt = stallCnt_q;

endmodule
